mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
Multi-cycle control FSM for the MIPS core. It sequences the shared PC/IR/regfile/ALU/memory datapath through FETCH, DCD, EXE, MEM and WB. It drives the same select encodings as the single-cycle decoder, so the datapath muxes are reused unchanged. It adds per-state write strobes and a memory ready handshake.

Parameters:
CNT_W, 32, width of the performance counters (used only with MC_PERF_CNT_EN).

Ports:
clk  input  1  core clock; all state changes on the rising edge.
rst  input  1  synchronous, active-high reset.
instr  input  32  IR contents. Stable from the cycle after FETCH.
zero  input  1  ALU zero flag, valid in EXE.
mem_rdy  input  1  data memory completes the access this cycle.
pc_wr  output  1  PC write enable.
ir_wr  output  1  IR write enable.
reg_wr  output  1  regfile write enable.
mem_wr  output  1  data memory write request.
mem_rd  output  1  data memory read request.
regdst  output  2  00 rt, 01 rd, 10 $31.
alusrc  output  1  0 register, 1 extended immediate.
memtoreg  output  2  00 ALU, 01 memory, 10 PC (link).
npc_sel  output  2  00 PC+4, 01 branch, 10 jump, 11 register.
ext_op  output  2  00 zero-extend, 01 sign-extend, 10 lui shift.
alu_ctr  output  2  00 add, 01 sub, 10 or, 11 slt.
state  output  3  current state, for debug.
instr_done  output  1  high in the last cycle of each instruction.
illegal  output  1  high for one cycle in DCD when the opcode/funct is undecoded.

Behaviour:
- State encoding: FETCH=0, DCD=1, EXE=2, MEM=3, WB=4. Codes 5-7 return to FETCH.
- Reset: on a clock edge with rst=1, state <= FETCH.
  - While rst=1, all strobes (pc_wr, ir_wr, reg_wr, mem_wr, mem_rd, instr_done, illegal) are forced to 0 combinationally.
  - While rst=1, all selects are 00/0.
- Outputs are combinational from state and instr. Every output not listed for a state is 0.
- FETCH:
  - Drives ir_wr=1, pc_wr=1, npc_sel=00.
  - Next state: DCD.
- DCD, instruction class decoded from instr:
  - j: pc_wr=1, npc_sel=10, done. Next state: FETCH.
  - jal: as j, plus reg_wr=1, regdst=10, memtoreg=10. Next state: FETCH.
  - jr: pc_wr=1, npc_sel=11, done. Next state: FETCH.
  - jalr: as jr, plus reg_wr=1, regdst=01, memtoreg=10. Next state: FETCH.
  - Link value is the current PC, which already holds PC+4.
  - Undecoded instruction: illegal=1, instr_done=1, behaves as a nop. Next state: FETCH.
  - All other instructions: next state EXE.
- EXE, common drive: alu_ctr, ext_op and alusrc per instruction.
  - addu: alu 00, alusrc 0.
  - subu: alu 01, alusrc 0.
  - slt: alu 11, alusrc 0.
  - addi/addiu: alu 00, ext 01, alusrc 1.
  - ori: alu 10, ext 00, alusrc 1.
  - lui: alu 10, ext 10, alusrc 1.
- EXE, next state:
  - beq: alu 01, alusrc 0. If zero=1, also pc_wr=1 and npc_sel=01. instr_done=1 either way. Next state: FETCH.
  - lw/sw: alu 00, ext 01, alusrc 1. Next state: MEM.
  - Others: next state WB.
- MEM:
  - lw: mem_rd=1, held until mem_rdy=1, then WB.
  - sw: mem_wr=1, held until mem_rdy=1, then FETCH with instr_done=1.
  - mem_rdy=0 keeps the FSM in MEM with the request held. There is no timeout.
- WB:
  - reg_wr=1 and instr_done=1. Next state: FETCH.
  - R-type: regdst=01, memtoreg=00.
  - Immediate ops: regdst=00, memtoreg=00.
  - lw: regdst=00, memtoreg=01.
- Latency with mem_rdy=1 on the first MEM cycle:
  - j/jal/jr/jalr: 2 cycles.
  - beq: 3 cycles.
  - sw: 4 cycles.
  - R-type/immediate: 4 cycles.
  - lw: 5 cycles.
  - Each mem_rdy=0 cycle adds 1.
- Reset mid-operation, including a held sw in MEM: the request drops in the same cycle rst rises. The next state is FETCH and no partial write strobe is emitted.

Optional Feature:
MC_PERF_CNT_EN.
- Defined: adds outputs cyc_cnt[CNT_W-1:0] and ret_cnt[CNT_W-1:0].
  - Both reset to 0 on rst.
  - cyc_cnt increments every non-reset cycle.
  - ret_cnt increments on each instr_done.
  - Both wrap modulo 2^CNT_W.
- Undefined: ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Package mc_pkg holds:
  - state codes;
  - opcode/funct constants (00/21, 00/23, 00/2a, 00/08, 00/09, 08, 09, 0d, 23, 2b, 04, 0f, 02, 03);
  - regdst/memtoreg/npc_sel/ext_op/alu_ctr encodings.
- Sub-module mc_decode: combinational instr -> one-hot instruction class plus illegal flag.
- mc_ctrl holds the state register, next-state logic and output logic.

Test Plan:
- addu $3,$1,$2 after reset: states 0,1,2,4, back to 0. ir_wr only in cycle 1. reg_wr=1, regdst=01 only in cycle 4. instr_done only in cycle 4.
- lw with mem_rdy low 2 cycles: MEM held 3 cycles with mem_rd=1. WB has memtoreg=01. Total 7 cycles.
- beq: zero=1 gives pc_wr=1, npc_sel=01 in EXE. zero=0 gives pc_wr=0 in EXE. Both take 3 cycles.
- jal (0x0C000010): DCD has pc_wr=1, npc_sel=10, reg_wr=1, regdst=10, memtoreg=10. Next state FETCH.
- Opcode 0x3F: illegal=1 for one cycle in DCD, no reg_wr/mem_wr, returns to FETCH. ret_cnt+1 when MC_PERF_CNT_EN is defined.
- sw with mem_rdy=0, rst=1 asserted in the second MEM cycle: mem_wr=0 that cycle, state=0 after the edge, no reg_wr.

Source files
------------

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared state codes, opcode/funct constants and datapath select encodings for mc_ctrl
package mc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_DCD   = 3'd1,
        ST_EXE   = 3'd2,
        ST_MEM   = 3'd3,
        ST_WB    = 3'd4
    } state_t;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_SLT   = 6'h2a;

    // Select encodings shared with the single-cycle decoder
    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] M2R_ALU   = 2'b00;
    localparam logic [1:0] M2R_MEM   = 2'b01;
    localparam logic [1:0] M2R_PC    = 2'b10;

    localparam logic [1:0] NPC_SEQ   = 2'b00;
    localparam logic [1:0] NPC_BR    = 2'b01;
    localparam logic [1:0] NPC_JMP   = 2'b10;
    localparam logic [1:0] NPC_REG   = 2'b11;

    localparam logic [1:0] EXT_ZERO  = 2'b00;
    localparam logic [1:0] EXT_SIGN  = 2'b01;
    localparam logic [1:0] EXT_LUI   = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_OR    = 2'b10;
    localparam logic [1:0] ALU_SLT   = 2'b11;

    // One-hot instruction class; all-zero means undecoded. addi covers addiu.
    typedef struct packed {
        logic addu;
        logic subu;
        logic slt;
        logic jr;
        logic jalr;
        logic addi;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
    } iclass_t;

    localparam int ICLS_W = $bits(iclass_t);

endpackage

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - combinational instruction classifier for mc_ctrl
// Ports:
//   instr   [31:0]        instruction register contents
//   cls     [ICLS_W-1:0]  one-hot instruction class (iclass_t layout)
//   illegal               opcode/funct not in the supported set
module mc_decode
    import mc_pkg::*;
(
    input  logic [31:0]       instr,
    output logic [ICLS_W-1:0] cls,
    output logic              illegal
);

    logic [5:0] op;
    logic [5:0] fn;
    iclass_t    c;
    logic       unused_fields;

    assign op = instr[31:26];
    assign fn = instr[5:0];
    // Register/immediate fields only matter to the datapath.
    assign unused_fields = ^instr[25:6];

    always_comb begin
        c = '0;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADDU: c.addu = 1'b1;
                    FN_SUBU: c.subu = 1'b1;
                    FN_SLT:  c.slt  = 1'b1;
                    FN_JR:   c.jr   = 1'b1;
                    FN_JALR: c.jalr = 1'b1;
                    default: ;
                endcase
            end
            OP_J:     c.j    = 1'b1;
            OP_JAL:   c.jal  = 1'b1;
            OP_BEQ:   c.beq  = 1'b1;
            OP_ADDI,
            OP_ADDIU: c.addi = 1'b1;
            OP_ORI:   c.ori  = 1'b1;
            OP_LUI:   c.lui  = 1'b1;
            OP_LW:    c.lw   = 1'b1;
            OP_SW:    c.sw   = 1'b1;
            default:  ;
        endcase
    end

    assign cls     = c;
    assign illegal = (c == '0);

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle MIPS control FSM (FETCH/DCD/EXE/MEM/WB)
// Optional: define MC_PERF_CNT_EN to add cyc_cnt/ret_cnt performance counters.
// Ports:
//   clk, rst (sync, active-high)
//   instr[31:0], zero, mem_rdy                       inputs
//   pc_wr, ir_wr, reg_wr, mem_wr, mem_rd             write strobes / memory requests
//   regdst, alusrc, memtoreg, npc_sel, ext_op, alu_ctr  datapath selects
//   state[2:0], instr_done, illegal                  status
//   cyc_cnt, ret_cnt [CNT_W-1:0]                     only with MC_PERF_CNT_EN
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_rdy,
    output logic        pc_wr,
    output logic        ir_wr,
    output logic        reg_wr,
    output logic        mem_wr,
    output logic        mem_rd,
    output logic [1:0]  regdst,
    output logic        alusrc,
    output logic [1:0]  memtoreg,
    output logic [1:0]  npc_sel,
    output logic [1:0]  ext_op,
    output logic [1:0]  alu_ctr,
    output logic [2:0]  state,
    output logic        instr_done,
    output logic        illegal
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt
`endif
);

    state_t  state_q;
    state_t  state_d;
    iclass_t cls;
    logic    dec_illegal;
    logic    is_jump;
    logic    is_rtype;

    mc_decode u_decode (
        .instr   (instr),
        .cls     (cls),
        .illegal (dec_illegal)
    );

    assign is_jump  = cls.j | cls.jal | cls.jr | cls.jalr;
    assign is_rtype = cls.addu | cls.subu | cls.slt;
    assign state    = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_FETCH: state_d = ST_DCD;
            ST_DCD:   state_d = (is_jump || dec_illegal) ? ST_FETCH : ST_EXE;
            ST_EXE: begin
                if (cls.beq)             state_d = ST_FETCH;
                else if (cls.lw || cls.sw) state_d = ST_MEM;
                else                     state_d = ST_WB;
            end
            ST_MEM: begin
                if (!mem_rdy)    state_d = ST_MEM;
                else if (cls.lw) state_d = ST_WB;
                else             state_d = ST_FETCH;
            end
            ST_WB:    state_d = ST_FETCH;
            default:  state_d = ST_FETCH;
        endcase
    end

    // Reset masks every output, so a held memory request drops in the same
    // cycle rst rises rather than one edge later.
    always_comb begin
        pc_wr      = 1'b0;
        ir_wr      = 1'b0;
        reg_wr     = 1'b0;
        mem_wr     = 1'b0;
        mem_rd     = 1'b0;
        regdst     = REGDST_RT;
        alusrc     = 1'b0;
        memtoreg   = M2R_ALU;
        npc_sel    = NPC_SEQ;
        ext_op     = EXT_ZERO;
        alu_ctr    = ALU_ADD;
        instr_done = 1'b0;
        illegal    = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    ir_wr = 1'b1;
                    pc_wr = 1'b1;
                end
                ST_DCD: begin
                    if (dec_illegal) begin
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                    end else if (is_jump) begin
                        pc_wr      = 1'b1;
                        instr_done = 1'b1;
                        npc_sel    = (cls.jr || cls.jalr) ? NPC_REG : NPC_JMP;
                        // Link writes the PC, which already holds PC+4.
                        if (cls.jal || cls.jalr) begin
                            reg_wr   = 1'b1;
                            memtoreg = M2R_PC;
                            regdst   = cls.jal ? REGDST_RA : REGDST_RD;
                        end
                    end
                end
                ST_EXE: begin
                    if (cls.subu || cls.beq) alu_ctr = ALU_SUB;
                    if (cls.slt)             alu_ctr = ALU_SLT;
                    if (cls.ori || cls.lui)  alu_ctr = ALU_OR;
                    if (cls.addi || cls.lw || cls.sw) begin
                        ext_op = EXT_SIGN;
                        alusrc = 1'b1;
                    end
                    if (cls.ori) alusrc = 1'b1;
                    if (cls.lui) begin
                        ext_op = EXT_LUI;
                        alusrc = 1'b1;
                    end
                    if (cls.beq) begin
                        instr_done = 1'b1;
                        if (zero) begin
                            pc_wr   = 1'b1;
                            npc_sel = NPC_BR;
                        end
                    end
                end
                ST_MEM: begin
                    mem_rd     = cls.lw;
                    mem_wr     = cls.sw;
                    instr_done = cls.sw & mem_rdy;
                end
                ST_WB: begin
                    reg_wr     = 1'b1;
                    instr_done = 1'b1;
                    regdst     = is_rtype ? REGDST_RD : REGDST_RT;
                    memtoreg   = cls.lw ? M2R_MEM : M2R_ALU;
                end
                default: ;
            endcase
        end
    end

`ifdef MC_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
            if (instr_done) ret_cnt <= ret_cnt + CNT_W'(1);
        end
    end
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - table-driven self-checking bench for mc_ctrl
module tb_mc_ctrl;

    localparam int CNT_W = 32;

    typedef struct packed {
        logic       pc_wr;
        logic       ir_wr;
        logic       reg_wr;
        logic       mem_wr;
        logic       mem_rd;
        logic [1:0] regdst;
        logic       alusrc;
        logic [1:0] memtoreg;
        logic [1:0] npc_sel;
        logic [1:0] ext_op;
        logic [1:0] alu_ctr;
        logic       instr_done;
        logic       illegal;
    } out_t;

    typedef struct packed {
        logic        rst;
        logic [31:0] instr;
        logic        zero;
        logic        rdy;
        logic [2:0]  st;
        out_t        o;
    } vec_t;

    localparam logic [31:0] I_ADDU = 32'h0022_1821;
    localparam logic [31:0] I_SUBU = 32'h0022_1823;
    localparam logic [31:0] I_SLT  = 32'h0022_182A;
    localparam logic [31:0] I_ADDI = 32'h2022_0005;
    localparam logic [31:0] I_ORI  = 32'h3422_00FF;
    localparam logic [31:0] I_LUI  = 32'h3C02_1234;
    localparam logic [31:0] I_LW   = 32'h8C22_0004;
    localparam logic [31:0] I_SW   = 32'hAC22_0004;
    localparam logic [31:0] I_BEQ  = 32'h1022_0004;
    localparam logic [31:0] I_J    = 32'h0800_0010;
    localparam logic [31:0] I_JAL  = 32'h0C00_0010;
    localparam logic [31:0] I_JR   = 32'h03E0_0008;
    localparam logic [31:0] I_JALR = 32'h0020_F809;
    localparam logic [31:0] I_BAD  = 32'hFC00_0000;
    localparam logic [31:0] I_ADD  = 32'h0022_1820;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        zero;
    logic        mem_rdy;
    logic        pc_wr, ir_wr, reg_wr, mem_wr, mem_rd, alusrc, instr_done, illegal;
    logic [1:0]  regdst, memtoreg, npc_sel, ext_op, alu_ctr;
    logic [2:0]  state;
`ifdef MC_PERF_CNT_EN
    logic [CNT_W-1:0] cyc_cnt, ret_cnt;
    logic [CNT_W-1:0] exp_cyc, exp_ret;
`endif

    int   checks = 0;
    int   errors = 0;
    int   row    = 0;
    vec_t vecs[$];

    mc_ctrl #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .zero       (zero),
        .mem_rdy    (mem_rdy),
        .pc_wr      (pc_wr),
        .ir_wr      (ir_wr),
        .reg_wr     (reg_wr),
        .mem_wr     (mem_wr),
        .mem_rd     (mem_rd),
        .regdst     (regdst),
        .alusrc     (alusrc),
        .memtoreg   (memtoreg),
        .npc_sel    (npc_sel),
        .ext_op     (ext_op),
        .alu_ctr    (alu_ctr),
        .state      (state),
        .instr_done (instr_done),
        .illegal    (illegal)
`ifdef MC_PERF_CNT_EN
        ,
        .cyc_cnt    (cyc_cnt),
        .ret_cnt    (ret_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mk(pc_wr, ir_wr, reg_wr, mem_wr, mem_rd, regdst, alusrc, memtoreg, npc_sel, ext_op, alu_ctr, done, illegal)
    function automatic out_t mk(int pc, int ir, int rw, int mw, int mr, int rd, int as,
                                int mt, int ns, int eo, int ac, int dn, int il);
        out_t o;
        o.pc_wr      = pc[0];
        o.ir_wr      = ir[0];
        o.reg_wr     = rw[0];
        o.mem_wr     = mw[0];
        o.mem_rd     = mr[0];
        o.regdst     = rd[1:0];
        o.alusrc     = as[0];
        o.memtoreg   = mt[1:0];
        o.npc_sel    = ns[1:0];
        o.ext_op     = eo[1:0];
        o.alu_ctr    = ac[1:0];
        o.instr_done = dn[0];
        o.illegal    = il[0];
        return o;
    endfunction

    function automatic vec_t mkv(logic r, logic [31:0] i, logic z, logic rdy, logic [2:0] s, out_t o);
        vec_t x;
        x.rst   = r;
        x.instr = i;
        x.zero  = z;
        x.rdy   = rdy;
        x.st    = s;
        x.o     = o;
        return x;
    endfunction

    function automatic void v(logic r, logic [31:0] i, logic z, logic rdy, logic [2:0] s, out_t o);
        vecs.push_back(mkv(r, i, z, rdy, s, o));
    endfunction

    task automatic run_row(input vec_t x);
        out_t got;
        @(negedge clk);
        rst     = x.rst;
        instr   = x.instr;
        zero    = x.zero;
        mem_rdy = x.rdy;
        #1;
        got = '{pc_wr, ir_wr, reg_wr, mem_wr, mem_rd, regdst, alusrc, memtoreg,
                npc_sel, ext_op, alu_ctr, instr_done, illegal};
        checks++;
        if (state !== x.st) begin
            errors++;
            $display("FAIL state row %0d instr %h: got %0d expected %0d", row, x.instr, state, x.st);
        end
        checks++;
        if (got !== x.o) begin
            errors++;
            $display("FAIL outputs row %0d state %0d instr %h: got %h expected %h",
                     row, x.st, x.instr, got, x.o);
        end
`ifdef MC_PERF_CNT_EN
        checks++;
        if (cyc_cnt !== exp_cyc) begin
            errors++;
            $display("FAIL cyc_cnt row %0d: got %0d expected %0d", row, cyc_cnt, exp_cyc);
        end
        checks++;
        if (ret_cnt !== exp_ret) begin
            errors++;
            $display("FAIL ret_cnt row %0d: got %0d expected %0d", row, ret_cnt, exp_ret);
        end
`endif
        @(posedge clk);
`ifdef MC_PERF_CNT_EN
        if (x.rst) begin
            exp_cyc = '0;
            exp_ret = '0;
        end else begin
            exp_cyc = exp_cyc + 1;
            if (x.o.instr_done) exp_ret = exp_ret + 1;
        end
`endif
        row++;
    endtask

    initial begin
        out_t z_o, f_o;
        z_o = '0;
        f_o = mk(1,1,0,0,0, 0,0,0,0,0,0, 0,0);

        // reset state
        v(1, 32'h0, 0, 1, 0, z_o);
        // addu: FETCH, DCD, EXE, WB
        v(0, I_ADDU, 0, 1, 0, f_o);
        v(0, I_ADDU, 0, 1, 1, z_o);
        v(0, I_ADDU, 0, 1, 2, z_o);
        v(0, I_ADDU, 0, 1, 4, mk(0,0,1,0,0, 1,0,0,0,0,0, 1,0));
        // subu / slt
        v(0, I_SUBU, 0, 1, 0, f_o);
        v(0, I_SUBU, 0, 1, 1, z_o);
        v(0, I_SUBU, 0, 1, 2, mk(0,0,0,0,0, 0,0,0,0,0,1, 0,0));
        v(0, I_SUBU, 0, 1, 4, mk(0,0,1,0,0, 1,0,0,0,0,0, 1,0));
        v(0, I_SLT,  0, 1, 0, f_o);
        v(0, I_SLT,  0, 1, 1, z_o);
        v(0, I_SLT,  0, 1, 2, mk(0,0,0,0,0, 0,0,0,0,0,3, 0,0));
        v(0, I_SLT,  0, 1, 4, mk(0,0,1,0,0, 1,0,0,0,0,0, 1,0));
        // immediates
        v(0, I_ADDI, 0, 1, 0, f_o);
        v(0, I_ADDI, 0, 1, 1, z_o);
        v(0, I_ADDI, 0, 1, 2, mk(0,0,0,0,0, 0,1,0,0,1,0, 0,0));
        v(0, I_ADDI, 0, 1, 4, mk(0,0,1,0,0, 0,0,0,0,0,0, 1,0));
        v(0, I_ORI,  0, 1, 0, f_o);
        v(0, I_ORI,  0, 1, 1, z_o);
        v(0, I_ORI,  0, 1, 2, mk(0,0,0,0,0, 0,1,0,0,0,2, 0,0));
        v(0, I_ORI,  0, 1, 4, mk(0,0,1,0,0, 0,0,0,0,0,0, 1,0));
        v(0, I_LUI,  0, 1, 0, f_o);
        v(0, I_LUI,  0, 1, 1, z_o);
        v(0, I_LUI,  0, 1, 2, mk(0,0,0,0,0, 0,1,0,0,2,2, 0,0));
        v(0, I_LUI,  0, 1, 4, mk(0,0,1,0,0, 0,0,0,0,0,0, 1,0));
        // lw with mem_rdy low for two cycles: 7 cycles total
        v(0, I_LW, 0, 1, 0, f_o);
        v(0, I_LW, 0, 1, 1, z_o);
        v(0, I_LW, 0, 1, 2, mk(0,0,0,0,0, 0,1,0,0,1,0, 0,0));
        v(0, I_LW, 0, 0, 3, mk(0,0,0,0,1, 0,0,0,0,0,0, 0,0));
        v(0, I_LW, 0, 0, 3, mk(0,0,0,0,1, 0,0,0,0,0,0, 0,0));
        v(0, I_LW, 0, 1, 3, mk(0,0,0,0,1, 0,0,0,0,0,0, 0,0));
        v(0, I_LW, 0, 1, 4, mk(0,0,1,0,0, 0,0,1,0,0,0, 1,0));
        // sw with immediate ready: 4 cycles
        v(0, I_SW, 0, 1, 0, f_o);
        v(0, I_SW, 0, 1, 1, z_o);
        v(0, I_SW, 0, 1, 2, mk(0,0,0,0,0, 0,1,0,0,1,0, 0,0));
        v(0, I_SW, 0, 1, 3, mk(0,0,0,1,0, 0,0,0,0,0,0, 1,0));
        // beq taken / not taken
        v(0, I_BEQ, 1, 1, 0, f_o);
        v(0, I_BEQ, 1, 1, 1, z_o);
        v(0, I_BEQ, 1, 1, 2, mk(1,0,0,0,0, 0,0,0,1,0,1, 1,0));
        v(0, I_BEQ, 0, 1, 0, f_o);
        v(0, I_BEQ, 0, 1, 1, z_o);
        v(0, I_BEQ, 0, 1, 2, mk(0,0,0,0,0, 0,0,0,0,0,1, 1,0));
        // jumps finish in DCD
        v(0, I_J,    0, 1, 0, f_o);
        v(0, I_J,    0, 1, 1, mk(1,0,0,0,0, 0,0,0,2,0,0, 1,0));
        v(0, I_JAL,  0, 1, 0, f_o);
        v(0, I_JAL,  0, 1, 1, mk(1,0,1,0,0, 2,0,2,2,0,0, 1,0));
        v(0, I_JR,   0, 1, 0, f_o);
        v(0, I_JR,   0, 1, 1, mk(1,0,0,0,0, 0,0,0,3,0,0, 1,0));
        v(0, I_JALR, 0, 1, 0, f_o);
        v(0, I_JALR, 0, 1, 1, mk(1,0,1,0,0, 1,0,2,3,0,0, 1,0));
        // undecoded opcode and undecoded funct
        v(0, I_BAD, 0, 1, 0, f_o);
        v(0, I_BAD, 0, 1, 1, mk(0,0,0,0,0, 0,0,0,0,0,0, 1,1));
        v(0, I_ADD, 0, 1, 0, f_o);
        v(0, I_ADD, 0, 1, 1, mk(0,0,0,0,0, 0,0,0,0,0,0, 1,1));
        v(0, I_ADDU, 0, 1, 0, f_o);

        rst     = 1'b1;
        instr   = '0;
        zero    = 1'b0;
        mem_rdy = 1'b1;
        @(posedge clk);
        @(posedge clk);
`ifdef MC_PERF_CNT_EN
        exp_cyc = '0;
        exp_ret = '0;
`endif

        foreach (vecs[k]) run_row(vecs[k]);

        // Finish the addu fetched above, then sw held in MEM and reset mid-request.
        run_row(mkv(0, I_ADDU, 0, 1, 1, z_o));
        run_row(mkv(0, I_ADDU, 0, 1, 2, z_o));
        run_row(mkv(0, I_ADDU, 0, 1, 4, mk(0,0,1,0,0, 1,0,0,0,0,0, 1,0)));
        run_row(mkv(0, I_SW, 0, 0, 0, f_o));
        run_row(mkv(0, I_SW, 0, 0, 1, z_o));
        run_row(mkv(0, I_SW, 0, 0, 2, mk(0,0,0,0,0, 0,1,0,0,1,0, 0,0)));
        run_row(mkv(0, I_SW, 0, 0, 3, mk(0,0,0,1,0, 0,0,0,0,0,0, 0,0)));
        run_row(mkv(1, I_SW, 0, 0, 3, z_o));
        run_row(mkv(0, I_SW, 0, 0, 0, f_o));
        // mem_rdy low outside MEM must not stall a jump
        run_row(mkv(0, I_J, 0, 0, 1, mk(1,0,0,0,0, 0,0,0,2,0,0, 1,0)));
        run_row(mkv(0, I_J, 0, 0, 0, f_o));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
